inst_control: RTL and testbench
===============================

Name: inst_control

Overview:
- Main instruction decoder for the five-stage logo-processor pipeline; sits at the decode stage.
- Maps the 5-bit instruction opcode to 11 one-hot/flag control bits that steer the register-file read muxes, ALU operand select, memory, write-back, branch and jump logic.
- Decode is combinational; all control outputs are registered, so they align with the decode/execute pipeline register.

Parameters:
- OPW, 5, opcode width; fixed at 5 and must not be overridden.

Ports:
- clock input 1 system clock, rising-edge active.
- reset input 1 asynchronous, active-low reset.
- opcode input 5 instruction bits [31:27].
- rs_rd1 output 1 read-port-1 address select: 0 = rs field, 1 = rd field.
- rt_rs2 output 1 read-port-2 address select: 0 = rt field, 1 = rs field.
- memToReg output 1 write-back data select: 1 = data-memory output, 0 = ALU result.
- reg_we output 1 register-file write enable.
- mem_we output 1 data-memory write enable.
- alu_imm output 1 ALU operand B select: 1 = sign-extended 17-bit immediate, 0 = register.
- br output 1 conditional branch instruction.
- jump output 1 PC loads the 27-bit target (j, jal).
- jal_ctrl output 1 write PC+1 into $r31.
- jr_ctrl output 1 PC loads the read-port-1 value.
- bne_blt output 1 branch condition: 0 = not-equal, 1 = less-than; meaningful only when br=1.

Behaviour:
- Interface: one clock, named clock; reset is asynchronous, active-low, named reset.
- While reset=0, all 11 outputs are 0 immediately, independent of clock. This is the NOP control word.
- Reset release has no extra latency. The first rising edge after release registers the decode of the current opcode.
- Latency: the decode of opcode sampled at rising edge N is visible on the outputs after edge N and held until edge N+1. There is no enable; the outputs update every cycle.
- Decode table (listed bits = 1, all others = 0):
  - 00000 R-type ALU: reg_we.
  - 00001 j: jump.
  - 00010 bne: rs_rd1, rt_rs2, br; bne_blt=0.
  - 00011 jal: reg_we, jump, jal_ctrl.
  - 00100 jr: rs_rd1, jr_ctrl. jump stays 0.
  - 00101 addi: reg_we, alu_imm.
  - 00110 blt: rs_rd1, rt_rs2, br, bne_blt.
  - 00111 sw: rs_rd1, rt_rs2, mem_we, alu_imm.
  - 01000 lw: memToReg, reg_we, alu_imm.
  - All other opcodes (01001–11111): all outputs 0, i.e. NOP. They never write registers or memory.
- Invariants on every registered control word:
  - mem_we and reg_we are never both 1.
  - At most one of br, jump and jr_ctrl is 1.
  - jal_ctrl=1 implies jump=1 and reg_we=1.
  - memToReg=1 implies reg_we=1.
- X/Z on opcode must not be resolved to a write enable. The default case drives NOP.

Optional Feature:
- Macro INST_CONTROL_ILLEGAL_OP_EN.
- When defined:
  - Adds output port illegal_op (1 bit, registered, reset to 0).
  - illegal_op is 1 for any opcode outside the nine decoded values; the other outputs still give NOP.
- When undefined:
  - The port does not exist.
  - Undefined opcodes silently produce NOP.

Test Plan:
- Reset: hold reset=0, opcode=5'b00011, toggle clock -> all outputs stay 0. Release reset -> after the next rising edge, reg_we=jump=jal_ctrl=1 and all others 0.
- Exhaustive sweep: apply opcode 0..31, one per clock -> each control word matches the decode table one cycle later; 01001..11111 give all zeros (illegal_op=1 when the macro is defined).
- Branch distinction: opcode 00010 then 00110 -> br=1, rs_rd1=1, rt_rs2=1 for both; bne_blt goes 0 then 1.
- Memory pair: opcode 01000 -> memToReg=1, reg_we=1, alu_imm=1, mem_we=0. Then 00111 -> mem_we=1, alu_imm=1, reg_we=0, memToReg=0.
- Async reset mid-stream: with opcode=00000 and reg_we=1 registered, drop reset between clock edges -> reg_we falls to 0 without a clock edge. It stays 0 until the first edge after release.
- Invariant check: random opcodes for 1000 cycles -> no cycle has mem_we&reg_we, and no cycle has more than one of br/jump/jr_ctrl.

Source files
------------

// File: rtl/inst_control.sv
// Decode-stage instruction decoder: 5-bit opcode -> registered 11-bit control word.
// Optional macro INST_CONTROL_ILLEGAL_OP_EN adds a registered illegal_op flag.
module inst_control #(
  parameter int OPW = 5
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  output logic           rs_rd1,
  output logic           rt_rs2,
  output logic           memToReg,
  output logic           reg_we,
  output logic           mem_we,
  output logic           alu_imm,
  output logic           br,
  output logic           jump,
  output logic           jal_ctrl,
  output logic           jr_ctrl,
`ifdef INST_CONTROL_ILLEGAL_OP_EN
  output logic           illegal_op,
`endif
  output logic           bne_blt
);

  typedef struct packed {
    logic rs_rd1;
    logic rt_rs2;
    logic mem_to_reg;
    logic reg_we;
    logic mem_we;
    logic alu_imm;
    logic br;
    logic jump;
    logic jal_ctrl;
    logic jr_ctrl;
    logic bne_blt;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{default: 1'b0};

  ctrl_t ctrl_d, ctrl_q;
  logic  illegal_d;

  // Opcode decode; anything not listed (including X/Z) falls to the NOP word.
  always_comb begin
    ctrl_d    = CTRL_NOP;
    illegal_d = 1'b0;
    case (opcode)
      5'b00000: ctrl_d.reg_we = 1'b1;
      5'b00001: ctrl_d.jump   = 1'b1;
      5'b00010: begin
        ctrl_d.rs_rd1 = 1'b1;
        ctrl_d.rt_rs2 = 1'b1;
        ctrl_d.br     = 1'b1;
      end
      5'b00011: begin
        ctrl_d.reg_we   = 1'b1;
        ctrl_d.jump     = 1'b1;
        ctrl_d.jal_ctrl = 1'b1;
      end
      5'b00100: begin
        ctrl_d.rs_rd1  = 1'b1;
        ctrl_d.jr_ctrl = 1'b1;
      end
      5'b00101: begin
        ctrl_d.reg_we  = 1'b1;
        ctrl_d.alu_imm = 1'b1;
      end
      5'b00110: begin
        ctrl_d.rs_rd1  = 1'b1;
        ctrl_d.rt_rs2  = 1'b1;
        ctrl_d.br      = 1'b1;
        ctrl_d.bne_blt = 1'b1;
      end
      5'b00111: begin
        ctrl_d.rs_rd1  = 1'b1;
        ctrl_d.rt_rs2  = 1'b1;
        ctrl_d.mem_we  = 1'b1;
        ctrl_d.alu_imm = 1'b1;
      end
      5'b01000: begin
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.reg_we     = 1'b1;
        ctrl_d.alu_imm    = 1'b1;
      end
      default: begin
        ctrl_d    = CTRL_NOP;
        illegal_d = 1'b1;
      end
    endcase
  end

  // Control word register aligned with the decode/execute pipeline register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl_q <= CTRL_NOP;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign rs_rd1   = ctrl_q.rs_rd1;
  assign rt_rs2   = ctrl_q.rt_rs2;
  assign memToReg = ctrl_q.mem_to_reg;
  assign reg_we   = ctrl_q.reg_we;
  assign mem_we   = ctrl_q.mem_we;
  assign alu_imm  = ctrl_q.alu_imm;
  assign br       = ctrl_q.br;
  assign jump     = ctrl_q.jump;
  assign jal_ctrl = ctrl_q.jal_ctrl;
  assign jr_ctrl  = ctrl_q.jr_ctrl;
  assign bne_blt  = ctrl_q.bne_blt;

`ifdef INST_CONTROL_ILLEGAL_OP_EN
  logic illegal_q;

  // Illegal-opcode flag register, same timing as the control word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal_op = illegal_q;
`else
  logic unused_illegal;
  assign unused_illegal = illegal_d;
`endif

endmodule

// File: tb/tb_inst_control.sv
// Self-checking bench for inst_control: table-driven opcode sweep plus reset,
// branch, memory and random-invariant sequences.
module tb_inst_control;

  logic       clock;
  logic       reset;
  logic [4:0] opcode;
  logic       rs_rd1, rt_rs2, memToReg, reg_we, mem_we, alu_imm;
  logic       br, jump, jal_ctrl, jr_ctrl, bne_blt;
`ifdef INST_CONTROL_ILLEGAL_OP_EN
  logic       illegal_op;
`endif

  int errors = 0;
  int checks = 0;

  inst_control dut (
    .clock    (clock),
    .reset    (reset),
    .opcode   (opcode),
    .rs_rd1   (rs_rd1),
    .rt_rs2   (rt_rs2),
    .memToReg (memToReg),
    .reg_we   (reg_we),
    .mem_we   (mem_we),
    .alu_imm  (alu_imm),
    .br       (br),
    .jump     (jump),
    .jal_ctrl (jal_ctrl),
    .jr_ctrl  (jr_ctrl),
`ifdef INST_CONTROL_ILLEGAL_OP_EN
    .illegal_op (illegal_op),
`endif
    .bne_blt  (bne_blt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {rs_rd1, rt_rs2, memToReg, reg_we, mem_we, alu_imm, br, jump, jal_ctrl, jr_ctrl, bne_blt}
  logic [10:0] out_w;
  assign out_w = {rs_rd1, rt_rs2, memToReg, reg_we, mem_we, alu_imm,
                  br, jump, jal_ctrl, jr_ctrl, bne_blt};

  localparam logic [10:0] W_NOP  = 11'b00000000000;
  localparam logic [10:0] W_RTYP = 11'b00010000000;
  localparam logic [10:0] W_J    = 11'b00000001000;
  localparam logic [10:0] W_BNE  = 11'b11000010000;
  localparam logic [10:0] W_JAL  = 11'b00010001100;
  localparam logic [10:0] W_JR   = 11'b10000000010;
  localparam logic [10:0] W_ADDI = 11'b00010100000;
  localparam logic [10:0] W_BLT  = 11'b11000010001;
  localparam logic [10:0] W_SW   = 11'b11001100000;
  localparam logic [10:0] W_LW   = 11'b00110100000;

  typedef struct {
    logic [4:0]  op;
    logic [10:0] exp;
    logic        ill;
  } vec_t;

  vec_t vecs[32];

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_ill(input string name, input logic exp);
`ifdef INST_CONTROL_ILLEGAL_OP_EN
    checks++;
    if (illegal_op !== exp) begin
      errors++;
      $display("FAIL %s: illegal_op got %b expected %b", name, illegal_op, exp);
    end
`endif
  endtask

  initial begin
    vecs[0] = '{5'd0, W_RTYP, 1'b0};
    vecs[1] = '{5'd1, W_J,    1'b0};
    vecs[2] = '{5'd2, W_BNE,  1'b0};
    vecs[3] = '{5'd3, W_JAL,  1'b0};
    vecs[4] = '{5'd4, W_JR,   1'b0};
    vecs[5] = '{5'd5, W_ADDI, 1'b0};
    vecs[6] = '{5'd6, W_BLT,  1'b0};
    vecs[7] = '{5'd7, W_SW,   1'b0};
    vecs[8] = '{5'd8, W_LW,   1'b0};
    for (int i = 9; i < 32; i++) vecs[i] = '{5'(i), W_NOP, 1'b1};

    // Reset held: outputs stay NOP across clock edges.
    reset  = 1'b0;
    opcode = 5'b00011;
    #1;
    check("reset_t0", out_w, W_NOP);
    check_ill("reset_t0_ill", 1'b0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_held", out_w, W_NOP);

    // Release: no edge yet -> still NOP; next edge -> jal word.
    reset = 1'b1;
    #1;
    check("release_pre_edge", out_w, W_NOP);
    @(negedge clock);
    check("release_first_edge", out_w, W_JAL);

    // Exhaustive sweep.
    for (int i = 0; i < 32; i++) begin
      opcode = vecs[i].op;
      @(negedge clock);
      check($sformatf("sweep_op%0d", i), out_w, vecs[i].exp);
      check_ill($sformatf("sweep_ill%0d", i), vecs[i].ill);
    end

    // Branch distinction.
    opcode = 5'b00010;
    @(negedge clock);
    check("branch_bne", out_w, W_BNE);
    opcode = 5'b00110;
    @(negedge clock);
    check("branch_blt", out_w, W_BLT);

    // Memory pair.
    opcode = 5'b01000;
    @(negedge clock);
    check("mem_lw", out_w, W_LW);
    opcode = 5'b00111;
    @(negedge clock);
    check("mem_sw", out_w, W_SW);

    // Async reset between edges.
    opcode = 5'b00000;
    @(negedge clock);
    check("async_pre", out_w, W_RTYP);
    #2 reset = 1'b0;
    #1;
    check("async_drop", out_w, W_NOP);
    @(posedge clock);
    #1;
    check("async_held_edge", out_w, W_NOP);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("async_release_pre_edge", out_w, W_NOP);
    @(negedge clock);
    check("async_release_edge", out_w, W_RTYP);

    // Random opcodes: decode and invariants each cycle.
    for (int n = 0; n < 1000; n++) begin
      logic [4:0]  op;
      logic [10:0] flow;
      op     = 5'($urandom_range(31, 0));
      opcode = op;
      @(negedge clock);
      check($sformatf("rand_op%0d", op), out_w, vecs[op].exp);
      check("inv_mem_reg_we", {10'b0, mem_we & reg_we}, 11'b0);
      flow = {10'b0, br} + {10'b0, jump} + {10'b0, jr_ctrl};
      check("inv_flow_onehot", {10'b0, (flow > 11'd1)}, 11'b0);
      check("inv_jal", {10'b0, jal_ctrl & ~(jump & reg_we)}, 11'b0);
      check("inv_m2r", {10'b0, memToReg & ~reg_we}, 11'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
